// File: rtl/read_bmap_row_pkg.sv
// Shared types for the bitmap row reader: 16.16 coordinates, pixel type, FSM states,
// the per-pixel return tag and the halfword selector.
package read_bmap_row_pkg;

    typedef logic [31:0] fix16_t;
    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    // Travels alongside each pixel from issue to output, in issue order.
    typedef struct packed {
        logic last;
        logic reuse;
        logic upper;
    } tag_t;

    function automatic pixel_t hw_sel(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/read_bmap_fifo.sv
// Generic synchronous FIFO, zero-latency head read; push while full is taken only if
// the same cycle pops.
module read_bmap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty  = (r_cnt == '0);
    assign w_full = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!w_full || w_pop);
    assign dout   = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/read_bmap_row.sv
// Walks a 16.16 path through a frame buffer, reading one halfword pixel per step; pixels
// stream out in order under pix_ready backpressure. READ_BMAP_WORD_REUSE_EN skips repeat-word reads.
module read_bmap_row
    import read_bmap_row_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int PIXEL_WIDTH = 16,
    parameter int PIPE_LEN    = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   req,
    input  logic [ADDR_WIDTH-1:0]  fb_base_in,
    input  logic [31:0]            wmod_in,
    input  logic [31:0]            xcur_in,
    input  logic [31:0]            ycur_in,
    input  logic [31:0]            hdx_in,
    input  logic [31:0]            hdy_in,
    input  logic [31:0]            cnt_in,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_resp,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   done
);
    localparam int CW = $clog2(PIPE_LEN + 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wmod;
    fix16_t                r_x;
    fix16_t                r_y;
    fix16_t                r_hdx;
    fix16_t                r_hdy;
    logic [31:0]           r_cnt;
    logic [31:0]           r_issued;
    logic [31:0]           r_acc;
    logic [CW-1:0]         r_infl;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_held;

    logic [31:0]           w_prod;
    logic [ADDR_WIDTH-1:0] w_byte;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic                  w_reuse;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_pix_vld;
    tag_t                  w_tag_in;
    tag_t                  w_tag;
    logic                  w_tag_empty;
    logic [DATA_WIDTH-1:0] w_dat;
    logic                  w_dat_empty;
    logic [DATA_WIDTH-1:0] w_word;
    pixel_t                w_pix;

    assign w_prod  = 32'(r_y[31:16]) * r_wmod;
    assign w_byte  = r_base + ADDR_WIDTH'(w_prod) + ADDR_WIDTH'({r_x[31:16], 1'b0});
    assign w_waddr = w_byte >> 2;

`ifdef READ_BMAP_WORD_REUSE_EN
    logic [ADDR_WIDTH-1:0] r_prev_waddr;
    logic                  r_prev_vld;

    assign w_reuse = r_prev_vld && (w_waddr == r_prev_waddr);

    always_ff @(posedge aclk) begin
        if (areset || r_state == ST_IDLE) begin
            r_prev_vld   <= 1'b0;
            r_prev_waddr <= '0;
        end else if (w_issue) begin
            r_prev_vld   <= 1'b1;
            r_prev_waddr <= w_waddr;
        end
    end
`else
    assign w_reuse = 1'b0;
`endif

    // A slot freed by this cycle's acceptance can be reused immediately, keeping one pixel per cycle.
    assign w_issue  = (r_state == ST_ISSUE) && ((r_infl < CW'(PIPE_LEN)) || w_accept);
    assign w_accept = w_pix_vld && pix_ready;

    assign w_tag_in.last  = (r_issued == r_cnt - 32'd1);
    assign w_tag_in.reuse = w_reuse;
    assign w_tag_in.upper = w_byte[1];

    read_bmap_fifo #(.DEPTH(PIPE_LEN), .WIDTH($bits(tag_t))) u_tag_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (w_issue),
        .din   (w_tag_in),
        .pop   (w_accept),
        .dout  (w_tag),
        .empty (w_tag_empty)
    );

    read_bmap_fifo #(.DEPTH(PIPE_LEN), .WIDTH(DATA_WIDTH)) u_dat_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (mem_resp && (r_state != ST_IDLE)),
        .din   (mem_rdata),
        .pop   (w_accept && !w_tag.reuse),
        .dout  (w_dat),
        .empty (w_dat_empty)
    );

    assign w_pix_vld = !w_tag_empty && (w_tag.reuse || !w_dat_empty);
    assign w_word    = w_tag.reuse ? r_held : w_dat;
    assign w_pix     = hw_sel(32'(w_word), w_tag.upper);

    assign pixel     = w_pix_vld ? PIXEL_WIDTH'(w_pix) : '0;
    assign pix_valid = w_pix_vld;
    assign pix_last  = w_pix_vld && w_tag.last;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_wmod     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_hdx      <= '0;
            r_hdy      <= '0;
            r_cnt      <= '0;
            r_issued   <= '0;
            r_acc      <= '0;
            r_infl     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_held     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_mem_req <= 1'b0;
            r_infl    <= r_infl + CW'(w_issue) - CW'(w_accept);
            if (w_accept && !w_tag.reuse) r_held <= w_dat;
            if (w_accept) r_acc <= r_acc + 32'd1;
            if (w_issue) begin
                r_x       <= r_x + r_hdx;
                r_y       <= r_y + r_hdy;
                r_issued  <= r_issued + 32'd1;
                r_mem_req <= !w_reuse;
                if (!w_reuse) r_mem_addr <= w_waddr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_base   <= fb_base_in;
                        r_wmod   <= wmod_in;
                        r_x      <= xcur_in;
                        r_y      <= ycur_in;
                        r_hdx    <= hdx_in;
                        r_hdy    <= hdy_in;
                        r_cnt    <= cnt_in;
                        r_issued <= '0;
                        r_acc    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= (cnt_in == 32'd0) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue && (r_issued + 32'd1 == r_cnt)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_acc + 32'(w_accept) == r_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_bmap_row.sv
// Directed bench for read_bmap_row: basic row, backpressure, empty row, vertical walk
// with address wrap, and reset mid-row followed by a clean repeat.
module tb_read_bmap_row;

`ifdef READ_BMAP_WORD_REUSE_EN
    localparam int EXP_READS = 9;
`else
    localparam int EXP_READS = 16;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] fb_base_in = '0, wmod_in = '0, xcur_in = '0, ycur_in = '0;
    logic [31:0] hdx_in = '0, hdy_in = '0, cnt_in = '0;
    logic        mem_req, mem_we, mem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] pixel;
    logic        pix_valid, pix_last, busy, done;
    logic        pix_ready = 1'b1;

    always #5 aclk = ~aclk;

    read_bmap_row dut (
        .aclk(aclk), .areset(areset), .req(req),
        .fb_base_in(fb_base_in), .wmod_in(wmod_in), .xcur_in(xcur_in), .ycur_in(ycur_in),
        .hdx_in(hdx_in), .hdy_in(hdy_in), .cnt_in(cnt_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pixel(pixel), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    // Two-cycle memory: rdata is the word index of the request.
    logic        p0_v = 1'b0, p1_v = 1'b0;
    logic [31:0] p0_a = '0, p1_a = '0;
    always @(posedge aclk) begin
        p0_v <= mem_req;
        p0_a <= mem_addr;
        p1_v <= p0_v;
        p1_a <= p0_a;
    end
    assign mem_resp  = p1_v;
    assign mem_rdata = p1_a;

    int n_chk = 0, n_err = 0;
    int cyc = 0, n_reads, n_resp, max_out, n_acc, n_done, busy_rise, done_cyc, last_acc_cyc;
    int exp_cnt;
    logic        prev_busy = 1'b0, stall_vld = 1'b0;
    logic [15:0] stall_pix;
    logic [15:0] exp_pix [16];
    logic [31:0] addr_log [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        cyc++;
        if (mem_req) begin
            if (n_reads < 16) addr_log[n_reads] = mem_addr;
            n_reads++;
        end
        if (mem_resp) n_resp++;
        if (n_reads - n_resp > max_out) max_out = n_reads - n_resp;
        if (stall_vld && pix_valid) chk("stall_hold", 32'(pixel), 32'(stall_pix));
        if (pix_valid && pix_ready) begin
            if (n_acc < exp_cnt) begin
                chk("pixel", 32'(pixel), 32'(exp_pix[n_acc]));
                chk("pix_last", 32'(pix_last), 32'(n_acc == exp_cnt - 1));
            end else begin
                chk("extra_pixel", 32'(n_acc), 32'(exp_cnt - 1));
            end
            n_acc++;
            last_acc_cyc = cyc;
        end
        stall_vld = pix_valid && !pix_ready;
        stall_pix = pixel;
        if (busy && !prev_busy) busy_rise = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 32'd0);
        end
        prev_busy = busy;
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_last"}, 32'(pix_last), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic run_row(input logic [31:0] base, input logic [31:0] wmod,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] dx, input logic [31:0] dy,
                           input logic [31:0] cnt, input bit toggle, input int rst_at);
        bit hit_rst = 0;
        n_reads = 0; n_resp = 0; max_out = 0; n_acc = 0; n_done = 0;
        busy_rise = -1; done_cyc = -1; last_acc_cyc = -1;
        fb_base_in = base; wmod_in = wmod; xcur_in = x; ycur_in = y;
        hdx_in = dx; hdy_in = dy; cnt_in = cnt; exp_cnt = int'(cnt);
        pix_ready = 1'b1;
        req = 1'b1;
        @(posedge aclk); #1;
        req = 1'b0;
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            @(posedge aclk); #1;
            if (toggle) pix_ready = ~pix_ready;
            // A request while busy must be ignored.
            if (toggle && i == 3) begin req = 1'b1; cnt_in = 32'd5; end
            else req = 1'b0;
            if (rst_at >= 0 && n_acc >= rst_at) begin
                areset = 1'b1;
                @(posedge aclk); #1;
                check_idle_outputs("reset_mid");
                areset = 1'b0;
                pix_ready = 1'b1;
                hit_rst = 1;
                break;
            end
        end
        req = 1'b0;
        pix_ready = 1'b1;
        repeat (6) @(posedge aclk);
        #1;
        if (hit_rst) chk("reset_no_done", 32'(n_done), 32'd0);
        else         chk("done_count", 32'(n_done), 32'd1);
    endtask

    task automatic check_basic_row(input string tag);
        chk({tag, "_pixels"}, 32'(n_acc), 32'd16);
        chk({tag, "_reads"}, 32'(n_reads), 32'(EXP_READS));
        chk({tag, "_first_waddr"}, addr_log[0], 32'h3C0);
        chk({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_acc_cyc + 1));
        chk({tag, "_max_outstanding_le4"}, 32'(max_out <= 4), 32'd1);
    endtask

    initial begin
        exp_pix = '{16'h0000, 16'h03C1, 16'h0000, 16'h03C2, 16'h0000, 16'h03C3, 16'h0000, 16'h03C4,
                    16'h0000, 16'h03C5, 16'h0000, 16'h03C6, 16'h0000, 16'h03C7, 16'h0000, 16'h03C8};
        exp_cnt = 16;
        n_reads = 0; n_resp = 0; max_out = 0; n_acc = 0; n_done = 0;
        repeat (3) @(posedge aclk);
        #1;
        check_idle_outputs("reset");
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        run_row(32'h0, 32'h500, 32'h10000, 32'h30000, 32'h10000, 32'h0, 32'd16, 1'b0, -1);
        check_basic_row("basic");

        run_row(32'h0, 32'h500, 32'h10000, 32'h30000, 32'h10000, 32'h0, 32'd16, 1'b1, -1);
        check_basic_row("bp");

        run_row(32'h0, 32'h500, 32'h10000, 32'h30000, 32'h10000, 32'h0, 32'd0, 1'b0, -1);
        chk("cnt0_reads", 32'(n_reads), 32'd0);
        chk("cnt0_pixels", 32'(n_acc), 32'd0);
        chk("cnt0_done_delay", 32'(done_cyc - busy_rise), 32'd1);

        // Base below zero with wmod 0xD00 wraps so rows 3,4,5 land on words 0x3C0/0x700/0xA40.
        for (int i = 0; i < 16; i++) exp_pix[i] = 16'h0000;
        run_row(32'hFFFF_E800, 32'hD00, 32'h10000, 32'h30000, 32'h0, 32'h10000, 32'd3, 1'b0, -1);
        chk("vert_pixels", 32'(n_acc), 32'd3);
        chk("vert_reads", 32'(n_reads), 32'd3);
        chk("vert_waddr0", addr_log[0], 32'h3C0);
        chk("vert_waddr1", addr_log[1], 32'h700);
        chk("vert_waddr2", addr_log[2], 32'hA40);

        exp_pix = '{16'h0000, 16'h03C1, 16'h0000, 16'h03C2, 16'h0000, 16'h03C3, 16'h0000, 16'h03C4,
                    16'h0000, 16'h03C5, 16'h0000, 16'h03C6, 16'h0000, 16'h03C7, 16'h0000, 16'h03C8};
        run_row(32'h0, 32'h500, 32'h10000, 32'h30000, 32'h10000, 32'h0, 32'd16, 1'b0, 4);
        run_row(32'h0, 32'h500, 32'h10000, 32'h30000, 32'h10000, 32'h0, 32'd16, 1'b0, -1);
        check_basic_row("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
